// File: rtl/arbitro_cajeros.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arbitro_cajeros: round-robin scheduler and 64-bit balance datapath for     |
// | NUM_TERM cash terminals sharing one account. Optional: LIMITE_RETIRO_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arbitro_cajeros #(
   parameter int          NUM_TERM   = 4,
   parameter logic [31:0] MAX_RETIRO = 32'd500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  CARGAR_BALANCE,
   input  logic [63:0]           BALANCE_INICIAL,
   input  logic [NUM_TERM-1:0]   SOLICITUD,
   input  logic [NUM_TERM-1:0]   TIPO_TRANS,
   input  logic [32*NUM_TERM-1:0] MONTO,
   output logic [NUM_TERM-1:0]   CONCEDIDO,
   output logic                  OCUPADO,
   output logic                  LISTO,
   output logic                  ENTREGAR_DINERO,
   output logic                  FONDOS_INSUFICIENTES,
   output logic                  LIMITE_EXCEDIDO,
   output logic                  BALANCE_ACTUALIZADO,
   output logic [63:0]           BALANCE
);

   localparam int IDX_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

   localparam logic [1:0] OCIOSO    = 2'd0;
   localparam logic [1:0] EJECUTA   = 2'd1;
   localparam logic [1:0] RESPUESTA = 2'd2;

   logic [1:0]          state_q,       state_d;
   logic [IDX_W-1:0]    ptr_q,         ptr_d;
   logic [IDX_W-1:0]    idx_q,         idx_d;
   logic                tipo_q,        tipo_d;
   logic [31:0]         monto_q,       monto_d;
   logic [NUM_TERM-1:0] concedido_q,   concedido_d;
   logic                ocupado_q,     ocupado_d;
   logic                listo_q,       listo_d;
   logic                entregar_q,    entregar_d;
   logic                fondos_q,      fondos_d;
   logic                limite_q,      limite_d;
   logic                actualizado_q, actualizado_d;
   logic [63:0]         balance_q,     balance_d;

   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [64:0]         suma;
   logic                viola_limite;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      int j;
      sel_found = 1'b0;
      sel_idx   = '0;
      j         = 0;
      for (int off = 0; off < NUM_TERM; off++) begin
         j = int'(ptr_q) + off;
         if (j >= NUM_TERM) j = j - NUM_TERM;
         if (!sel_found && SOLICITUD[j]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(j);
         end
      end
   end

   assign suma = {1'b0, balance_q} + {33'b0, monto_q};

`ifdef LIMITE_RETIRO_EN
   assign viola_limite = (monto_q > MAX_RETIRO);
`else
   assign viola_limite = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= OCIOSO;
         ptr_q         <= '0;
         idx_q         <= '0;
         tipo_q        <= 1'b0;
         monto_q       <= '0;
         concedido_q   <= '0;
         ocupado_q     <= 1'b0;
         listo_q       <= 1'b0;
         entregar_q    <= 1'b0;
         fondos_q      <= 1'b0;
         limite_q      <= 1'b0;
         actualizado_q <= 1'b0;
         balance_q     <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         idx_q         <= idx_d;
         tipo_q        <= tipo_d;
         monto_q       <= monto_d;
         concedido_q   <= concedido_d;
         ocupado_q     <= ocupado_d;
         listo_q       <= listo_d;
         entregar_q    <= entregar_d;
         fondos_q      <= fondos_d;
         limite_q      <= limite_d;
         actualizado_q <= actualizado_d;
         balance_q     <= balance_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OCIOSO:    if (!CARGAR_BALANCE && sel_found) state_d = EJECUTA;
         EJECUTA:   state_d = RESPUESTA;
         RESPUESTA: state_d = OCIOSO;
         default:   state_d = OCIOSO;
      endcase
   end

   // Registered outputs are computed one cycle ahead, so LISTO and the flags
   // are visible exactly while the FSM sits in RESPUESTA.
   always_comb begin
      ptr_d         = ptr_q;
      idx_d         = idx_q;
      tipo_d        = tipo_q;
      monto_d       = monto_q;
      concedido_d   = concedido_q;
      balance_d     = balance_q;
      listo_d       = 1'b0;
      entregar_d    = 1'b0;
      fondos_d      = 1'b0;
      limite_d      = 1'b0;
      actualizado_d = 1'b0;
      ocupado_d     = (state_d != OCIOSO);
      case (state_q)
         OCIOSO: begin
            if (CARGAR_BALANCE) begin
               balance_d = BALANCE_INICIAL;
            end else if (sel_found) begin
               idx_d                = sel_idx;
               tipo_d               = TIPO_TRANS[sel_idx];
               monto_d              = MONTO[32*int'(sel_idx) +: 32];
               concedido_d          = '0;
               concedido_d[sel_idx] = 1'b1;
            end
         end
         EJECUTA: begin
            listo_d = 1'b1;
            if (tipo_q && viola_limite) begin
               limite_d = 1'b1;
            end else if (tipo_q && ({32'b0, monto_q} > balance_q)) begin
               fondos_d = 1'b1;
            end else if (tipo_q) begin
               balance_d     = balance_q - {32'b0, monto_q};
               entregar_d    = 1'b1;
               actualizado_d = 1'b1;
            end else begin
               balance_d     = suma[64] ? {64{1'b1}} : suma[63:0];
               actualizado_d = 1'b1;
            end
         end
         RESPUESTA: begin
            concedido_d = '0;
            ptr_d       = (idx_q == IDX_W'(NUM_TERM-1)) ? '0 : idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign CONCEDIDO            = concedido_q;
   assign OCUPADO              = ocupado_q;
   assign LISTO                = listo_q;
   assign ENTREGAR_DINERO      = entregar_q;
   assign FONDOS_INSUFICIENTES = fondos_q;
   assign LIMITE_EXCEDIDO      = limite_q;
   assign BALANCE_ACTUALIZADO  = actualizado_q;
   assign BALANCE              = balance_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_cajeros.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arbitro_cajeros: directed self-checking bench for arbitro_cajeros.      |
// | Follows LIMITE_RETIRO_EN the same way as the design. Revision: 1.0         |
// +----------------------------------------------------------------------------+
module tb_arbitro_cajeros;

   localparam int NT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            cargar;
   logic [63:0]     bal_ini;
   logic [NT-1:0]   sol;
   logic [NT-1:0]   tipo;
   logic [32*NT-1:0] monto;
   logic [NT-1:0]   concedido;
   logic            ocupado, listo, entregar, fondos, limite, actualizado;
   logic [63:0]     balance;

   int n_checks = 0;
   int n_err    = 0;
   logic [63:0] exp_bal;

   always #5 clk = ~clk;

   arbitro_cajeros #(.NUM_TERM(NT), .MAX_RETIRO(32'd500)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .CARGAR_BALANCE       (cargar),
      .BALANCE_INICIAL      (bal_ini),
      .SOLICITUD            (sol),
      .TIPO_TRANS           (tipo),
      .MONTO                (monto),
      .CONCEDIDO            (concedido),
      .OCUPADO              (ocupado),
      .LISTO                (listo),
      .ENTREGAR_DINERO      (entregar),
      .FONDOS_INSUFICIENTES (fondos),
      .LIMITE_EXCEDIDO      (limite),
      .BALANCE_ACTUALIZADO  (actualizado),
      .BALANCE              (balance)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Flag order: {LISTO, ENTREGAR, FONDOS, LIMITE, ACTUALIZADO}
   function automatic logic [63:0] flags();
      return {59'b0, listo, entregar, fondos, limite, actualizado};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cargar_balance(input logic [63:0] v);
      cargar  = 1'b1;
      bal_ini = v;
      cyc(1);
      cargar  = 1'b0;
      check("load", balance, v);
   endtask

   // Issues one request from terminal t and checks grant, result and return to idle.
   task automatic transaccion(input string tag, input int t, input logic es_retiro,
                              input logic [31:0] m, input logic [4:0] exp_flags,
                              input logic [63:0] exp_b);
      logic [NT-1:0] oh;
      oh                  = '0;
      oh[t]               = 1'b1;
      sol                 = oh;
      tipo                = es_retiro ? oh : '0;
      monto[32*t +: 32]   = m;
      cyc(1);
      check({tag, "_grant"}, {60'b0, concedido}, {60'b0, oh});
      check({tag, "_busy"}, {63'b0, ocupado}, 64'd1);
      check({tag, "_nolisto"}, {63'b0, listo}, 64'd0);
      cyc(1);
      check({tag, "_flags"}, flags(), {59'b0, exp_flags});
      check({tag, "_bal"}, balance, exp_b);
      check({tag, "_grant_held"}, {60'b0, concedido}, {60'b0, oh});
      sol = '0;
      cyc(1);
      check({tag, "_idle"}, {58'b0, concedido, ocupado, listo}, 64'd0);
   endtask

   initial begin
      rst     = 1'b0;
      cargar  = 1'b0;
      bal_ini = '0;
      sol     = '0;
      tipo    = '0;
      monto   = '0;
      cyc(2);
      check("reset_bal", balance, 64'd0);
      check("reset_out", {57'b0, concedido, ocupado, listo, entregar}, 64'd0);
      rst = 1'b1;
      cyc(1);

      // Withdrawal accepted; pointer moves to 1
      cargar_balance(64'd1000);
      transaccion("ret300", 0, 1'b1, 32'd300, 5'b11001, 64'd700);

      // Insufficient funds, then exact-balance withdrawal (pointer wraps to 2)
      transaccion("ret800", 2, 1'b1, 32'd800, 5'b10100, 64'd700);
      transaccion("ret700", 2, 1'b1, 32'd700, 5'b11001, 64'd0);

      // Saturating deposit; CARGAR_BALANCE during EJECUTA is ignored
      cargar_balance(64'hFFFF_FFFF_FFFF_FFFB);
      sol              = 4'b0010;
      tipo             = 4'b0000;
      monto[63:32]     = 32'd10;
      cyc(1);
      check("sat_grant", {60'b0, concedido}, 64'h2);
      cargar  = 1'b1;
      bal_ini = 64'd5;
      cyc(1);
      cargar  = 1'b0;
      check("sat_flags", flags(), 64'b10001);
      check("sat_bal", balance, 64'hFFFF_FFFF_FFFF_FFFF);
      sol = '0;
      cyc(1);
      check("sat_bal_after", balance, 64'hFFFF_FFFF_FFFF_FFFF);

      // Withdrawal above MAX_RETIRO (pointer at 2 selects terminal 3)
      cargar_balance(64'd1000);
`ifdef LIMITE_RETIRO_EN
      exp_bal = 64'd1000;
      transaccion("ret501", 3, 1'b1, 32'd501, 5'b10010, exp_bal);
`else
      exp_bal = 64'd499;
      transaccion("ret501", 3, 1'b1, 32'd501, 5'b11001, exp_bal);
`endif

      // Zero-amount deposit by terminal 1 leaves pointer at 2
      transaccion("dep0", 1, 1'b0, 32'd0, 5'b10001, exp_bal);

      // Asynchronous reset in the middle of EJECUTA
      sol           = 4'b0100;
      tipo          = 4'b0100;
      monto[95:64]  = 32'd100;
      cyc(1);
      check("abort_grant", {60'b0, concedido}, 64'h4);
      #2 rst = 1'b0;
      #1;
      check("async_bal", balance, 64'd0);
      check("async_out", {57'b0, concedido, ocupado, listo, entregar}, 64'd0);
      sol = '0;
      cyc(2);
      rst = 1'b1;
      cyc(2);
      check("post_reset_bal", balance, 64'd0);

      // Four simultaneous deposits: round-robin from terminal 0, 3-cycle spacing
      sol   = 4'b1111;
      tipo  = 4'b0000;
      for (int i = 0; i < NT; i++) monto[32*i +: 32] = 32'd10;
      for (int t = 0; t < NT; t++) begin
         cyc(1);
         check("rr_grant", {60'b0, concedido}, 64'd1 << t);
         cyc(1);
         check("rr_flags", flags(), 64'b10001);
         check("rr_bal", balance, 64'd10 * (t + 1));
         sol[t] = 1'b0;
         cyc(1);
         check("rr_gap", {60'b0, concedido}, 64'd0);
      end
      check("rr_final", balance, 64'd40);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
